alu_src_sel_pipe: RTL

Parametrised, registered ALU operand selector for the multicycle MIPS datapath. It generalises the fixed 4:1 ALU source-A mux to NUM_SRC sources of WIDTH bits and registers the selected operand behind a valid/ready handshake. This lets the control unit issue operand selections ahead of the ALU stage. It sits between the datapath registers (PC, A, B, MDR, immediates) and one ALU input port; one instance serves each ALU operand.

---
 rtl/alu_src_pkg.sv | 21 ++
 rtl/alu_src_skid_buf.sv | 77 +++++++
 rtl/alu_src_sel_pipe.sv | 117 +++++++++++
 3 files changed

// File: rtl/alu_src_pkg.sv
// ============================================================================
// Module      : alu_src_pkg
// Description : Shared ALU operand-source encodings and select legality helper.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package alu_src_pkg;

   localparam int SRC_PC  = 0;
   localparam int SRC_B   = 1;
   localparam int SRC_A   = 2;
   localparam int SRC_MDR = 3;

   function automatic logic sel_legal(input int unsigned sel, input int unsigned num_src);
      return (sel < num_src);
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_src_skid_buf.sv
// ============================================================================
// Module      : alu_src_skid_buf
// Description : Two-entry (output + skid) valid/ready stage with registered
//               in_ready, so upstream never sees a path from out_ready.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_src_skid_buf #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
);

   logic              main_valid_q, main_valid_d;
   logic [DATA_W-1:0] main_data_q,  main_data_d;
   logic              skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0] skid_data_q,  skid_data_d;
   logic              accept;
   logic              xfer;

   assign in_ready  = !skid_valid_q;
   assign accept    = in_valid && !skid_valid_q;
   assign xfer      = main_valid_q && out_ready;
   assign out_data  = main_data_q;
   assign out_valid = main_valid_q;

   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (xfer) begin
         // A full skid implies no acceptance this cycle, so skid refills main.
         if (skid_valid_q) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            main_data_d  = in_data;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (accept) begin
         if (main_valid_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
         end else begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/alu_src_sel_pipe.sv
// ============================================================================
// Module      : alu_src_sel_pipe
// Description : Registered NUM_SRC:1 ALU operand selector with valid/ready
//               handshake and sticky illegal-select flag. Define
//               ALU_SRC_SKID_EN to add a skid entry with registered in_ready.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_src_sel_pipe
   import alu_src_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int NUM_SRC = 4,
   parameter int SEL_W   = $clog2(NUM_SRC)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_SRC*WIDTH-1:0] src_bus,
   input  logic [SEL_W-1:0]         sel,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [SEL_W-1:0]         out_sel,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     err_sel,
   input  logic                     err_clr
);

   logic [WIDTH-1:0] sel_data;
   logic             sel_ok;
   logic             accept;
   logic             err_sel_q, err_sel_d;

   // No source matches an out-of-range index, so illegal selects yield zero.
   always_comb begin
      sel_data = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (sel == SEL_W'(k)) sel_data = src_bus[k*WIDTH +: WIDTH];
      end
   end

   assign sel_ok = sel_legal(32'(sel), NUM_SRC);
   assign accept = in_valid && in_ready;

`ifdef ALU_SRC_SKID_EN
   logic [SEL_W+WIDTH-1:0] buf_out;

   alu_src_skid_buf #(
      .DATA_W (SEL_W + WIDTH)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .in_data   ({sel, sel_data}),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (buf_out),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   assign out_data = buf_out[WIDTH-1:0];
   assign out_sel  = buf_out[SEL_W+WIDTH-1:WIDTH];
`else
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [SEL_W-1:0] out_sel_q,   out_sel_d;

   assign in_ready  = !out_valid_q || out_ready;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = sel_data;
         out_sel_d   = sel;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
      end
   end
`endif

   // A fresh illegal acceptance outranks a simultaneous clear.
   always_comb begin
      err_sel_d = err_sel_q;
      if (accept && !sel_ok) err_sel_d = 1'b1;
      else if (err_clr)      err_sel_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) err_sel_q <= 1'b0;
      else       err_sel_q <= err_sel_d;
   end

   assign err_sel = err_sel_q;

endmodule

`default_nettype wire
